// File: rtl/cpu_checker_pkg.sv
// Shared types and constants for the CPU trace-line syntax checker.
package cpu_checker_pkg;

  // format_type encodings
  localparam logic [1:0] FMT_NONE = 2'b00;
  localparam logic [1:0] FMT_REG  = 2'b01;
  localparam logic [1:0] FMT_MEM  = 2'b10;

  // Fixed-width hex fields, sized to the 4-bit digit counter
  localparam logic [3:0] PC_DIG   = 4'd8;
  localparam logic [3:0] DATA_DIG = 4'd8;

  // One state per syntactic position within a trace line
  typedef enum logic [4:0] {
    S_IDLE,
    S_CARET,
    S_TIME,
    S_AT,
    S_PC,
    S_COLON,
    S_SP1,
    S_DOLLAR,
    S_STAR,
    S_GRF,
    S_ADDR,
    S_SP2,
    S_LT,
    S_EQ,
    S_SP3,
    S_DATA,
    S_DONE_REG,
    S_DONE_MEM
  } state_t;

  // Character class flags, one per token kind the FSM cares about
  typedef struct packed {
    logic is_dec;
    logic is_hex;
    logic is_space;
    logic is_caret;
    logic is_at;
    logic is_colon;
    logic is_dollar;
    logic is_star;
    logic is_lt;
    logic is_eq;
    logic is_hash;
  } char_class_t;

endpackage

// File: rtl/cpu_checker_fsm_char_class.sv
// Combinational ASCII classifier for the trace checker.
// Optional macro CPU_CHECKER_UPPER_HEX_EN: hex class also accepts 'A'-'F'.
module cpu_checker_fsm_char_class
  import cpu_checker_pkg::*;
(
  input  logic [7:0]  i_char,
  output char_class_t o_class
);

  // Decode the character into independent class flags
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    o_class           = '0;
    o_class.is_dec    = (i_char >= "0") && (i_char <= "9");
`ifdef CPU_CHECKER_UPPER_HEX_EN
    o_class.is_hex    = o_class.is_dec ||
                        ((i_char >= "a") && (i_char <= "f")) ||
                        ((i_char >= "A") && (i_char <= "F"));
`else
    o_class.is_hex    = o_class.is_dec ||
                        ((i_char >= "a") && (i_char <= "f"));
`endif
    o_class.is_space  = (i_char == " ");
    o_class.is_caret  = (i_char == "^");
    o_class.is_at     = (i_char == "@");
    o_class.is_colon  = (i_char == ":");
    o_class.is_dollar = (i_char == "$");
    o_class.is_star   = (i_char == "*");
    o_class.is_lt     = (i_char == "<");
    o_class.is_eq     = (i_char == "=");
    o_class.is_hash   = (i_char == "#");
  end

endmodule

// File: rtl/cpu_checker_fsm.sv
// Streaming syntax checker for CPU trace lines, one ASCII char per clock.
// Flags each well-formed register-write (01) or memory-write (10) line for
// the single cycle after its terminating '#'.
// Optional macro CPU_CHECKER_UPPER_HEX_EN (in char_class): uppercase hex digits.
module cpu_checker_fsm
  import cpu_checker_pkg::*;
#(
  parameter int TIME_MAX_DIG = 4,
  parameter int GRF_MAX_DIG  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] char,
  output logic [1:0] format_type
);

  localparam logic [3:0] L_TIME_MAX = 4'(TIME_MAX_DIG);
  localparam logic [3:0] L_GRF_MAX  = 4'(GRF_MAX_DIG);

  state_t      r_state;
  state_t      w_next_state;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_next;
  logic        r_is_mem;
  logic        w_is_mem_next;
  char_class_t w_cls;

  cpu_checker_fsm_char_class u_char_class (
    .i_char  (char),
    .o_class (w_cls)
  );

  // State, digit counter and line-type flag registers with synchronous reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_is_mem <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_cnt    <= w_cnt_next;
      r_is_mem <= w_is_mem_next;
    end
  end

  // Next-state logic: any character not accepted in the current state drops to IDLE
  always_comb begin
    w_next_state  = S_IDLE;
    w_cnt_next    = r_cnt;
    w_is_mem_next = r_is_mem;
    case (r_state)
      S_CARET: begin
        if (w_cls.is_dec) begin w_next_state = S_TIME; w_cnt_next = 4'd1; end
      end
      S_TIME: begin
        if (w_cls.is_dec && (r_cnt < L_TIME_MAX)) begin
          w_next_state = S_TIME; w_cnt_next = r_cnt + 4'd1;
        end else if (w_cls.is_at) begin
          w_next_state = S_AT;
        end
      end
      S_AT: begin
        if (w_cls.is_hex) begin w_next_state = S_PC; w_cnt_next = 4'd1; end
      end
      S_PC: begin
        if (w_cls.is_hex && (r_cnt < PC_DIG)) begin
          w_next_state = S_PC; w_cnt_next = r_cnt + 4'd1;
        end else if (w_cls.is_colon && (r_cnt == PC_DIG)) begin
          w_next_state = S_COLON;
        end
      end
      S_COLON, S_SP1: begin
        if (w_cls.is_space) begin
          w_next_state = S_SP1;
        end else if (w_cls.is_dollar) begin
          w_next_state = S_DOLLAR; w_is_mem_next = 1'b0;
        end else if (w_cls.is_star) begin
          w_next_state = S_STAR; w_is_mem_next = 1'b1;
        end
      end
      S_DOLLAR: begin
        if (w_cls.is_dec) begin w_next_state = S_GRF; w_cnt_next = 4'd1; end
      end
      S_GRF: begin
        if (w_cls.is_dec && (r_cnt < L_GRF_MAX)) begin
          w_next_state = S_GRF; w_cnt_next = r_cnt + 4'd1;
        end else if (w_cls.is_space) begin
          w_next_state = S_SP2;
        end else if (w_cls.is_lt) begin
          w_next_state = S_LT;
        end
      end
      S_STAR: begin
        if (w_cls.is_hex) begin w_next_state = S_ADDR; w_cnt_next = 4'd1; end
      end
      S_ADDR: begin
        if (w_cls.is_hex && (r_cnt < PC_DIG)) begin
          w_next_state = S_ADDR; w_cnt_next = r_cnt + 4'd1;
        end else if (w_cls.is_space && (r_cnt == PC_DIG)) begin
          w_next_state = S_SP2;
        end else if (w_cls.is_lt && (r_cnt == PC_DIG)) begin
          w_next_state = S_LT;
        end
      end
      S_SP2: begin
        if (w_cls.is_space)   w_next_state = S_SP2;
        else if (w_cls.is_lt) w_next_state = S_LT;
      end
      S_LT: begin
        if (w_cls.is_eq) w_next_state = S_EQ;
      end
      S_EQ, S_SP3: begin
        if (w_cls.is_space) begin
          w_next_state = S_SP3;
        end else if (w_cls.is_hex) begin
          w_next_state = S_DATA; w_cnt_next = 4'd1;
        end
      end
      S_DATA: begin
        if (w_cls.is_hex && (r_cnt < DATA_DIG)) begin
          w_next_state = S_DATA; w_cnt_next = r_cnt + 4'd1;
        end else if (w_cls.is_hash && (r_cnt == DATA_DIG)) begin
          w_next_state = r_is_mem ? S_DONE_MEM : S_DONE_REG;
        end
      end
      default: ; // IDLE and DONE_* only leave on '^', handled below
    endcase
    // A caret always restarts the parse, whatever was in progress
    if (w_cls.is_caret) w_next_state = S_CARET;
  end

  // Output decoded from the state register alone
  always_comb begin
    format_type = FMT_NONE;
    case (r_state)
      S_DONE_REG: format_type = FMT_REG;
      S_DONE_MEM: format_type = FMT_MEM;
      default:    format_type = FMT_NONE;
    endcase
  end

endmodule

// File: tb/tb_cpu_checker_fsm.sv
// Self-checking bench for cpu_checker_fsm: table of trace lines plus
// hand-written reset sequences, with a scoreboard queue of expected outputs.
module tb_cpu_checker_fsm;

  logic       clk;
  logic       tb_reset;
  logic [7:0] tb_char;
  logic [1:0] format_type;

  int checks = 0;
  int errors = 0;

  logic [1:0] exp_q[$];

  typedef struct {
    string      line;
    logic [1:0] fmt;   // expected right after the line's last char
  } vec_t;

  vec_t vecs[$];

`ifdef CPU_CHECKER_UPPER_HEX_EN
  localparam logic [1:0] UP_REG = 2'b01;
  localparam logic [1:0] UP_MEM = 2'b10;
`else
  localparam logic [1:0] UP_REG = 2'b00;
  localparam logic [1:0] UP_MEM = 2'b00;
`endif

  cpu_checker_fsm #(
    .TIME_MAX_DIG (4),
    .GRF_MAX_DIG  (4)
  ) dut (
    .clk         (clk),
    .reset       (tb_reset),
    .char        (tb_char),
    .format_type (format_type)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [1:0] got, input logic [1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", name, got, exp);
    end
  endtask

  // Drive one char on the falling edge, compare just after the rising edge
  task automatic drive(input logic [7:0] c, input logic [1:0] exp, input string name);
    logic [1:0] e;
    @(negedge clk);
    tb_char = c;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check(name, format_type, e);
  endtask

  // Send a whole string; only the final char may produce a non-zero flag
  task automatic send_line(input string s, input logic [1:0] fmt, input string tag);
    for (int i = 0; i < s.len(); i++)
      drive(s[i], (i == s.len() - 1) ? fmt : 2'b00, $sformatf("%s[%0d]", tag, i));
  endtask

  // Hold reset low for one edge while presenting a char, output must be idle
  task automatic reset_cycle(input logic [7:0] c, input string name);
    @(negedge clk);
    tb_reset = 1'b0;
    tb_char  = c;
    @(posedge clk);
    #1;
    check(name, format_type, 2'b00);
    @(negedge clk);
    tb_reset = 1'b1;
  endtask

  initial begin
    vecs.push_back('{"^7836@000030f4:   *00002ffc<=19521025#", 2'b10});
    vecs.push_back('{"^1@00003000: $31 <= 00000001#",          2'b01});
    vecs.push_back('{"^24 2@00003000: $31 <= 00000001#",       2'b00});
    vecs.push_back('{"^1@00003000: $31 <= 00000001#",          2'b01});
    vecs.push_back('{"^12345@00003000: $1 <= 00000001#",       2'b00});
    vecs.push_back('{"^9999@0000300: $1 <= 00000001#",         2'b00});
    vecs.push_back('{"^9999@00003000: $1234 <= ffffffff#",     2'b01});
    vecs.push_back('{"0",                                      2'b00});
    vecs.push_back('{"^1@00003000: $12345 <= 00000001#",       2'b00});
    vecs.push_back('{"^1@00003000: *00002ffc <= 00000001#",    2'b10});
    vecs.push_back('{"^1@00003000: $1 <= 0000001#",            2'b00});
    vecs.push_back('{"^1@00003000: $1 <= 000000011#",          2'b00});
    vecs.push_back('{"^1@00003000: $1 < = 00000001#",          2'b00});
    vecs.push_back('{"^1@0000^2@00003000:$7<=deadbeef#",       2'b01});
    vecs.push_back('{"^3@00003000: $1 <= 0000ABCD#",           UP_REG});
    vecs.push_back('{"^3@0000ABCD: *0000ABCD <= 00000001#",    UP_MEM});
    vecs.push_back('{"^3@00003000: *0000300 <= 00000001#",     2'b00});

    tb_reset = 1'b0;
    tb_char  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", format_type, 2'b00);
    @(negedge clk);
    tb_reset = 1'b1;

    for (int v = 0; v < vecs.size(); v++)
      send_line(vecs[v].line, vecs[v].fmt, $sformatf("vec%0d", v));

    // Reset mid-line aborts the line; its remainder must not be flagged
    send_line("^1@00003000: $31 <= 0000", 2'b00, "midrst_pre");
    reset_cycle("0", "midrst_rst");
    send_line("0001#", 2'b00, "midrst_post");

    // Reset on the very cycle '#' is sampled suppresses the flag
    send_line("^1@00003000: $31 <= 00000001", 2'b00, "hashrst_pre");
    reset_cycle("#", "hashrst_rst");

    // Flag lasts exactly one cycle, then a new line is still recognised
    send_line("^5@00003000: *00002ffc<=00000000#", 2'b10, "post_mem");
    drive(" ", 2'b00, "post_mem_drop");
    send_line("^5@00003000: $0 <= 00000000#", 2'b01, "post_reg");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
